// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified instruction/data memory between the
//   fetch stage (read only) and the load/store stage. One access per cycle;
//   data has priority, but after STARVE_MAX consecutive data grants while
//   fetch waits, fetch is forced through. Read data returns one cycle after
//   the grant and is routed to whichever requester owned that access.
//
// Parameters
//   ADDR_W      byte-address width of both request ports and the memory
//   DATA_W      data / instruction word width
//   STARVE_MAX  data grants tolerated while fetch waits (1..15)
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   if_req/if_addr               fetch request; if_gnt (comb) accepts it
//   if_rvalid/if_rdata           fetch response, one cycle after if_gnt
//   d_req/d_we/d_addr/d_wdata    data request; d_gnt (comb) accepts it
//   d_rvalid/d_rdata             load response, one cycle after d_gnt
//   d_err                        one-cycle pulse: misaligned data request
//   mem_addr/mem_we/mem_wdata    memory drive (combinational mux)
//   mem_rdata                    memory read data, valid one cycle later
//
// Optional build macro MEM_ARB_STATS_EN adds saturating 16-bit counters:
//   stat_if_stall  cycles with fetch requesting but not granted
//   stat_d_stall   cycles with an aligned data request not granted
//   stat_forced    cycles where fetch was forced past an aligned data request
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_stall,
  output logic [15:0]       stat_d_stall,
  output logic [15:0]       stat_forced
`endif
);

  // One-hot encoding so each rvalid is a direct decode of a single flop.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner;
  logic [3:0] starveCnt;
  logic       errReg;
  logic       dOk;
  logic       dMisaligned;
  logic       starveFull;

  assign dOk         = d_req & (d_addr[1:0] == 2'b00);
  assign dMisaligned = d_req & (d_addr[1:0] != 2'b00);
  assign starveFull  = (starveCnt == STARVE_LIM);

  // Fetch wins only when data has nothing legal to do or fetch has starved.
  assign if_gnt = reset_n & if_req & (~dOk | starveFull);
  assign d_gnt  = reset_n & dOk & ~if_gnt;

  assign mem_addr  = if_gnt ? if_addr : d_addr;
  assign mem_we    = d_gnt & d_we;
  assign mem_wdata = d_wdata;

  // Responses are masked while reset is held so a read granted just before
  // reset never surfaces, even in the reset cycle itself.
  assign if_rvalid = reset_n & (owner == OWN_IF);
  assign d_rvalid  = reset_n & (owner == OWN_D);
  assign d_err     = reset_n & errReg;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner     <= OWN_NONE;
      starveCnt <= '0;
      errReg    <= 1'b0;
    end else begin
      if (if_gnt) begin
        owner <= OWN_IF;
      end else if (d_gnt && !d_we) begin
        owner <= OWN_D;
      end else begin
        owner <= OWN_NONE;
      end

      // A waiting fetch is always beaten by a data grant, so counting data
      // grants while if_req is high counts exactly the cycles fetch lost.
      if (if_gnt || !if_req) begin
        starveCnt <= '0;
      end else if (d_gnt && !starveFull) begin
        starveCnt <= starveCnt + 4'd1;
      end

      errReg <= dMisaligned;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_if_stall <= '0;
      stat_d_stall  <= '0;
      stat_forced   <= '0;
    end else begin
      if (if_req && !if_gnt && stat_if_stall != '1) begin
        stat_if_stall <= stat_if_stall + 16'd1;
      end
      if (dOk && !d_gnt && stat_d_stall != '1) begin
        stat_d_stall <= stat_d_stall + 16'd1;
      end
      if (if_gnt && dOk && stat_forced != '1) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

endmodule
